// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 inverse cipher: FSM states, round
// count, block type and GF(2^8) helpers (polynomial 0x11b).
package aes_pkg;

    localparam int NR = 10;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Multiply by x in GF(2^8), reducing by 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product, shift-and-xor over the bits of b
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// InvMixColumns for one 32-bit column; col[31:24] is row 0.
module aes_inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col[31:24];
    assign a1 = col[23:16];
    assign a2 = col[15:8];
    assign a3 = col[7:0];

    // Circulant matrix rows {0e,0b,0d,09} rotated per output row
    assign mixed[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign mixed[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign mixed[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign mixed[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);

endmodule

// File: rtl/inv_sbox.sv
// AES inverse S-box: inverse affine map followed by the GF(2^8)
// multiplicative inverse, computed rather than tabulated.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] result
);

    // Inverse as value^254; zero maps to zero without a special case
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] acc;
        logic [7:0] pw;
        acc = 8'h01;
        pw  = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) acc = gf_mul(acc, pw);
            pw = gf_mul(pw, pw);
        end
        return acc;
    endfunction

    logic [7:0] pre;

    // Undo the forward affine map: rotl by 1, 3 and 6, then xor 0x05
    assign pre = {value[6:0], value[7]} ^ {value[4:0], value[7:5]} ^
                 {value[1:0], value[7:2]} ^ 8'h05;

    assign result = gf_inv(pre);

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: one round per clock on a single state
// register. Round keys come from an external store addressed by rk_idx.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. The offering side holds data stable while valid is high and not
// yet accepted; out_data is held constant in DONE until out_ready.
module aes_inv_cipher
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         key_valid,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output state_e       fsm_state
);

    state_e     state;
    logic [3:0] round_cnt;
    block_t     state_reg;
    block_t     shifted;
    block_t     subbed;
    block_t     keyed;
    block_t     mixed;

    // Byte n sits at bits [127-8n -: 8], row n%4, column n/4.
    // InvShiftRows: row r of column c is taken from column (c - r) mod 4.
    genvar gc, gr;
    generate
        for (gc = 0; gc < 4; gc++) begin : g_col
            for (gr = 0; gr < 4; gr++) begin : g_row
                localparam int DST = 127 - 8 * (gr + 4 * gc);
                localparam int SRC = 127 - 8 * (gr + 4 * ((gc - gr + 4) % 4));
                assign shifted[DST -: 8] = state_reg[SRC -: 8];
                inv_sbox u_inv_sbox (
                    .value  (shifted[DST -: 8]),
                    .result (subbed[DST -: 8])
                );
            end
            aes_inv_mix_column u_inv_mix (
                .col   (keyed[127 - 32 * gc -: 32]),
                .mixed (mixed[127 - 32 * gc -: 32])
            );
        end
    endgenerate

    // Key is added before InvMixColumns, so the final round simply skips the mix
    assign keyed = subbed ^ rk_data;

    assign in_ready  = (state == IDLE) && key_valid && !rst;
    assign out_valid = (state == DONE);
    assign out_data  = state_reg;
    assign fsm_state = state;

    // Key index: last round key while idle, counter while iterating, key 0 otherwise
    always_comb begin
        case (state)
            IDLE:    rk_idx = 4'(NR);
            ROUND:   rk_idx = round_cnt;
            default: rk_idx = 4'd0;
        endcase
    end

    // Load with initial key add, nine full rounds, final round, hold until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round_cnt <= 4'd0;
            state_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= in_data ^ rk_data;
                        round_cnt <= 4'(NR - 1);
                        state     <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= mixed;
                    round_cnt <= round_cnt - 4'd1;
                    if (round_cnt == 4'd1) state <= FINAL;
                end
                FINAL: begin
                    state_reg <= keyed;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
